bit_serial_alu: RTL and testbench

Multi-cycle bit-serial ALU that time-multiplexes a single `bit_slice` across a WIDTH-bit operand pair, one bit per clock, LSB first. It is the driving side of the bit-slice interface: it sequences operands, carry chain and control into the slice and reassembles result and flags. It is the area-minimal alternative to the parallel ALU for low-throughput datapaths.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/bit_slice.sv | 45 ++++
 rtl/bit_serial_alu.sv | 203 ++++++++++++++++++++
 tb/tb_bit_serial_alu.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU and its bit slice:
//   alu_op_e     operation encoding carried on the 3-bit op / cntrl buses
//   alu_state_e  sequencer states of bit_serial_alu
//   is_legal_op  true for the six defined operation codes (001 and 111 unused)
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        PASS_B = 3'b000,
        ADD    = 3'b010,
        SUB    = 3'b011,
        AND    = 3'b100,
        OR     = 3'b101,
        XOR    = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return !((op == 3'b001) || (op == 3'b111));
    endfunction

endpackage

// File: rtl/bit_slice.sv
// -----------------------------------------------------------------------------
// bit_slice
// One-bit ALU slice. Purely combinational; the caller supplies one operand
// bit pair per cycle and owns the carry register.
//
// Ports:
//   a, b       in   operand bits
//   carry_in   in   carry from the previous (less significant) bit
//   subtract   in   1 = invert b into the adder (A - B with carry_in = 1)
//   cntrl      in   operation code (alu_op_e encoding)
//   result     out  result bit for the selected operation
//   carry_out  out  adder carry; meaningful only for ADD/SUB
// -----------------------------------------------------------------------------
module bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic       subtract,
    input  logic [2:0] cntrl,
    output logic       result,
    output logic       carry_out
);

    logic b_eff;
    logic sum;

    always_comb begin
        b_eff     = b ^ subtract;
        sum       = a ^ b_eff ^ carry_in;
        carry_out = (a & b_eff) | (carry_in & (a ^ b_eff));

        // Logic ops use the raw b bit; only the adder sees the inverted one.
        case (alu_op_e'(cntrl))
            PASS_B:   result = b;
            ADD, SUB: result = sum;
            AND:      result = a & b;
            OR:       result = a | b;
            XOR:      result = a ^ b;
            default:  result = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// -----------------------------------------------------------------------------
// bit_serial_alu
// Multi-cycle bit-serial ALU. A single bit_slice is time-multiplexed across a
// WIDTH-bit operand pair, one bit per clock, LSB first. Operands shift out of
// a_sh/b_sh, result bits shift into the MSB of res_sh, and the carry chain is
// closed through carry_q.
//
// Parameters:
//   WIDTH      operand/result width (>= 2)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   request, sampled in IDLE or DONE
//   op         in   operation code (alu_op_e), sampled with start
//   a, b       in   operands, sampled with start
//   busy       out  high while bits are being processed
//   done       out  one-cycle pulse, result and flags valid
//   illegal    out  one-cycle pulse, start rejected (op 001 / 111)
//   result     out  result, updated only on entry to DONE
//   negative, zero, overflow, carry_out
//              out  status flags, held with result
//
// Configuration macro:
//   BIT_SERIAL_ALU_FLAGS_EN  defined: flags computed on entry to DONE.
//                            undefined: all four flags tied to 0.
// -----------------------------------------------------------------------------
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH);

    alu_state_e       state;
    alu_state_e       state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    alu_op_e          op_q;
    logic             illegal_q;

    logic             accept;
    logic             reject;
    logic             last_bit;
    logic             slice_res;
    logic             slice_cout;
    logic [WIDTH-1:0] res_full;

    // Single datapath slice fed from the LSBs of the operand shift registers.
    bit_slice u_slice (
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .carry_in  (carry_q),
        .subtract  (op_q == SUB),
        .cntrl     (op_q),
        .result    (slice_res),
        .carry_out (slice_cout)
    );

    // Full result as it will look after the final shift; used on the last
    // processing edge so result and flags land together on entry to DONE.
    assign res_full = {slice_res, res_sh[WIDTH-1:1]};

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state and status decode ----
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        last_bit  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                accept = start && is_legal_op(op);
                reject = start && !is_legal_op(op);
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                last_bit = (cnt == CNT_W'(WIDTH - 1));
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                accept = start && is_legal_op(op);
                reject = start && !is_legal_op(op);
                state_nxt = accept ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- operand load / bit processing ----
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            result_q  <= '0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            op_q      <= PASS_B;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= reject;
            if (accept) begin
                a_sh    <= a;
                b_sh    <= b;
                op_q    <= alu_op_e'(op);
                cnt     <= '0;
                // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                carry_q <= (alu_op_e'(op) == SUB);
            end else if (state == RUN) begin
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                res_sh  <= res_full;
                carry_q <= slice_cout;
                cnt     <= cnt + CNT_W'(1);
                if (last_bit) begin
                    result_q <= res_full;
                end
            end
        end
    end

    assign illegal = illegal_q;
    assign result  = result_q;

`ifdef BIT_SERIAL_ALU_FLAGS_EN
    logic neg_q;
    logic zero_q;
    logic ovf_q;
    logic cout_q;
    logic is_arith;

    assign is_arith = (op_q == ADD) || (op_q == SUB);

    // ---- flag capture on the final processing edge ----
    // During the MSB cycle carry_q is the carry into the MSB and slice_cout
    // the carry out of it, so overflow needs no extra capture register.
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
        end else if (last_bit) begin
            neg_q  <= slice_res;
            zero_q <= (res_full == '0);
            ovf_q  <= is_arith & (carry_q ^ slice_cout);
            cout_q <= is_arith & slice_cout;
        end
    end

    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;
`else
    assign negative  = 1'b0;
    assign zero      = 1'b0;
    assign overflow  = 1'b0;
    assign carry_out = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_alu.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_alu
// Two ALU instances (WIDTH=8 and WIDTH=64) share one clock and reset. A
// transaction-level model predicts busy/done/illegal/result/flags for each
// instance and is compared against both on every falling edge. Directed
// sequences with literal expectations pin the model; a random phase follows.
// -----------------------------------------------------------------------------
module tb_bit_serial_alu;

`ifdef BIT_SERIAL_ALU_FLAGS_EN
    localparam logic FLAGS_EN = 1'b1;
`else
    localparam logic FLAGS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] res;
        logic        neg;
        logic        zero;
        logic        ovf;
        logic        cout;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i [2];
    logic [2:0]  op_i    [2];
    logic [63:0] a_i     [2];
    logic [63:0] b_i     [2];

    logic        busy_o  [2];
    logic        done_o  [2];
    logic        ill_o   [2];
    logic        neg_o   [2];
    logic        zero_o  [2];
    logic        ovf_o   [2];
    logic        cout_o  [2];
    logic [7:0]  res8;
    logic [63:0] res64;
    logic [63:0] res_o   [2];

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    bit_serial_alu #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start_i[0]),
        .op        (op_i[0]),
        .a         (a_i[0][7:0]),
        .b         (b_i[0][7:0]),
        .busy      (busy_o[0]),
        .done      (done_o[0]),
        .illegal   (ill_o[0]),
        .result    (res8),
        .negative  (neg_o[0]),
        .zero      (zero_o[0]),
        .overflow  (ovf_o[0]),
        .carry_out (cout_o[0])
    );

    bit_serial_alu #(.WIDTH(64)) dut64 (
        .clk       (clk),
        .reset     (reset),
        .start     (start_i[1]),
        .op        (op_i[1]),
        .a         (a_i[1]),
        .b         (b_i[1]),
        .busy      (busy_o[1]),
        .done      (done_o[1]),
        .illegal   (ill_o[1]),
        .result    (res64),
        .negative  (neg_o[1]),
        .zero      (zero_o[1]),
        .overflow  (ovf_o[1]),
        .carry_out (cout_o[1])
    );

    assign res_o[0] = {56'd0, res8};
    assign res_o[1] = res64;

    function automatic int wof(input int k);
        return (k == 0) ? 8 : 64;
    endfunction

    // Reference arithmetic on w-bit two's-complement values.
    function automatic exp_t compute(input int w, input logic [2:0] o,
                                     input logic [63:0] a, input logic [63:0] b);
        exp_t        r;
        logic [64:0] full;
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bm   = b & mask;
        r    = '0;
        full = '0;
        case (o)
            3'b000: r.res = bm;
            3'b010: begin
                full   = {1'b0, am} + {1'b0, bm};
                r.res  = full[63:0] & mask;
                r.cout = full[w];
                r.ovf  = (am[w-1] == bm[w-1]) && (r.res[w-1] != am[w-1]);
            end
            3'b011: begin
                full   = {1'b0, am} + {1'b0, (~bm & mask)} + 65'd1;
                r.res  = full[63:0] & mask;
                r.cout = full[w];
                r.ovf  = (am[w-1] != bm[w-1]) && (r.res[w-1] != am[w-1]);
            end
            3'b100: r.res = am & bm;
            3'b101: r.res = am | bm;
            3'b110: r.res = am ^ bm;
            default: r.res = '0;
        endcase
        r.neg  = FLAGS_EN & r.res[w-1];
        r.zero = FLAGS_EN & (r.res == 64'd0);
        r.ovf  = FLAGS_EN & r.ovf;
        r.cout = FLAGS_EN & r.cout;
        return r;
    endfunction

    // Model: phase 0 idle, 1 running with rem edges left, 2 result presented.
    int   phase [2];
    int   rem   [2];
    exp_t pend  [2];
    exp_t cur   [2];
    logic e_ill [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                phase[k] <= 0;
                rem[k]   <= 0;
                cur[k]   <= '0;
                e_ill[k] <= 1'b0;
            end else begin
                e_ill[k] <= 1'b0;
                if (phase[k] == 1) begin
                    rem[k] <= rem[k] - 1;
                    if (rem[k] == 1) begin
                        phase[k] <= 2;
                        cur[k]   <= pend[k];
                    end
                end else if (start_i[k] && op_i[k] != 3'b001 && op_i[k] != 3'b111) begin
                    pend[k]  <= compute(wof(k), op_i[k], a_i[k], b_i[k]);
                    rem[k]   <= wof(k);
                    phase[k] <= 1;
                end else begin
                    e_ill[k] <= start_i[k];
                    phase[k] <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("busy_w%0d", wof(k)),    64'(busy_o[k]), 64'(phase[k] == 1));
                check($sformatf("done_w%0d", wof(k)),    64'(done_o[k]), 64'(phase[k] == 2));
                check($sformatf("illegal_w%0d", wof(k)), 64'(ill_o[k]),  64'(e_ill[k]));
                check($sformatf("result_w%0d", wof(k)),  res_o[k],       cur[k].res);
                check($sformatf("neg_w%0d", wof(k)),     64'(neg_o[k]),  64'(cur[k].neg));
                check($sformatf("zero_w%0d", wof(k)),    64'(zero_o[k]), 64'(cur[k].zero));
                check($sformatf("ovf_w%0d", wof(k)),     64'(ovf_o[k]),  64'(cur[k].ovf));
                check($sformatf("cout_w%0d", wof(k)),    64'(cout_o[k]), 64'(cur[k].cout));
            end
        end
    end

    task automatic issue(input int k, input logic [2:0] o, input logic [63:0] av, input logic [63:0] bv);
        @(negedge clk);
        start_i[k] = 1'b1;
        op_i[k]    = o;
        a_i[k]     = av;
        b_i[k]     = bv;
        @(negedge clk);
        start_i[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int cyc);
        cyc = 0;
        while (done_o[k] !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 200) begin
            n_errors++;
            $display("FAIL wait_done_w%0d: done not seen, waited %0d cycles, required <= 64", wof(k), cyc);
        end
    endtask

    function automatic logic [63:0] rnd_operand(input int w);
        logic [63:0] msb;
        msb = 64'd1 << (w - 1);
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return msb;
            3:       return msb - 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int   cyc;
        logic seen;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_i[k] = 1'b0;
            op_i[k]    = 3'b000;
            a_i[k]     = '0;
            b_i[k]     = '0;
        end
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", 64'(busy_o[0]), 64'd0);
        check("reset_done", 64'(done_o[1]), 64'd0);
        check("reset_result", res_o[1], 64'd0);

        // 8-bit signed overflow on add
        issue(0, 3'b010, 64'h7F, 64'h01);
        wait_done(0, cyc);
        check("add_latency", 64'(cyc), 64'd8);
        check("add_result", res_o[0], 64'h80);
        check("add_neg", 64'(neg_o[0]), 64'(FLAGS_EN));
        check("add_ovf", 64'(ovf_o[0]), 64'(FLAGS_EN));
        check("add_cout", 64'(cout_o[0]), 64'd0);
        check("add_zero", 64'(zero_o[0]), 64'd0);

        // subtract: equal operands, then borrow
        issue(0, 3'b011, 64'h05, 64'h05);
        wait_done(0, cyc);
        check("sub_eq_result", res_o[0], 64'h00);
        check("sub_eq_zero", 64'(zero_o[0]), 64'(FLAGS_EN));
        check("sub_eq_cout", 64'(cout_o[0]), 64'(FLAGS_EN));
        check("sub_eq_ovf", 64'(ovf_o[0]), 64'd0);
        issue(0, 3'b011, 64'h00, 64'h01);
        wait_done(0, cyc);
        check("sub_brw_result", res_o[0], 64'hFF);
        check("sub_brw_cout", 64'(cout_o[0]), 64'd0);
        check("sub_brw_neg", 64'(neg_o[0]), 64'(FLAGS_EN));

        // illegal op codes from IDLE
        issue(0, 3'b001, 64'h12, 64'h34);
        check("ill001_pulse", 64'(ill_o[0]), 64'd1);
        check("ill001_busy", 64'(busy_o[0]), 64'd0);
        check("ill001_held", res_o[0], 64'hFF);
        issue(0, 3'b111, 64'h12, 64'h34);
        check("ill111_pulse", 64'(ill_o[0]), 64'd1);
        check("ill111_busy", 64'(busy_o[0]), 64'd0);
        check("ill111_held", res_o[0], 64'hFF);

        // start mid-run is ignored; start in DONE is accepted back-to-back
        issue(0, 3'b010, 64'h10, 64'h20);
        repeat (3) @(negedge clk);
        start_i[0] = 1'b1; op_i[0] = 3'b110; a_i[0] = 64'hAA; b_i[0] = 64'h55;
        @(negedge clk);
        start_i[0] = 1'b0;
        wait_done(0, cyc);
        check("midrun_result", res_o[0], 64'h30);
        start_i[0] = 1'b1; op_i[0] = 3'b011; a_i[0] = 64'h09; b_i[0] = 64'h03;
        @(negedge clk);
        start_i[0] = 1'b0;
        check("b2b_busy", 64'(busy_o[0]), 64'd1);
        wait_done(0, cyc);
        check("b2b_latency", 64'(cyc), 64'd8);
        check("b2b_result", res_o[0], 64'h06);

        // 64-bit logic ops
        issue(1, 3'b100, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        wait_done(1, cyc);
        check("and64", res_o[1], 64'hF000_F000_F000_F000);
        check("and64_ovf", 64'(ovf_o[1]), 64'd0);
        check("and64_cout", 64'(cout_o[1]), 64'd0);
        issue(1, 3'b101, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        wait_done(1, cyc);
        check("or64", res_o[1], 64'hFFF0_FFF0_FFF0_FFF0);
        check("or64_cout", 64'(cout_o[1]), 64'd0);
        issue(1, 3'b110, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        wait_done(1, cyc);
        check("xor64", res_o[1], 64'h0FF0_0FF0_0FF0_0FF0);
        check("xor64_ovf", 64'(ovf_o[1]), 64'd0);
        issue(1, 3'b000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        wait_done(1, cyc);
        check("passb64", res_o[1], 64'hFF00_FF00_FF00_FF00);
        check("passb64_latency", 64'(cyc), 64'd64);

        // reset in the middle of a run
        issue(0, 3'b010, 64'h33, 64'h44);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(busy_o[0]), 64'd0);
        check("rst_result8", res_o[0], 64'd0);
        check("rst_result64", res_o[1], 64'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_o[0] === 1'b1) seen = 1'b1;
        end
        check("rst_no_done", 64'(seen), 64'd0);
        issue(0, 3'b010, 64'h01, 64'h01);
        wait_done(0, cyc);
        check("post_rst_add", res_o[0], 64'h02);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < 2; k++) begin
                start_i[k] = ($urandom_range(0, 3) == 0);
                op_i[k]    = 3'($urandom_range(0, 7));
                a_i[k]     = rnd_operand(wof(k));
                b_i[k]     = rnd_operand(wof(k));
            end
        end
        @(negedge clk);
        reset = 1'b0;
        start_i[0] = 1'b0;
        start_i[1] = 1'b0;
        repeat (70) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
